// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter feeding the 7-segment display driver.
// Optional macro BIN2BCD_OVF_EN: out-of-range values raise ovf_o and show all-E digits.
module bin2bcd_seq #(
   parameter int BIN_WIDTH = 14,
   parameter int DIGITS    = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic [BIN_WIDTH-1:0]  bin_i,
   input  logic [DIGITS-1:0]     dp_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  ovf_o,
   output logic [DIGITS*4-1:0]   bcd_o,
   output logic [DIGITS-1:0]     dots_o
);

   localparam int CW = $clog2(BIN_WIDTH + 1);
   localparam int SW = DIGITS * 4;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

   state_e               state_q, state_d;
   logic [BIN_WIDTH-1:0] bin_q, bin_d;
   logic [SW-1:0]        scratch_q, scratch_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [DIGITS-1:0]    dots_hold_q, dots_hold_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [SW-1:0]        bcd_q, bcd_d;
   logic [DIGITS-1:0]    dots_q, dots_d;
   logic [3:0]           nib, adj;

`ifdef BIN2BCD_OVF_EN
   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) r = r * 64'd10;
      return r;
   endfunction

   localparam logic [63:0] MAX_V = pow10(DIGITS) - 64'd1;

   logic ovf_hold_q, ovf_hold_d;
   logic ovf_q, ovf_d;
   assign ovf_o = ovf_q;
`else
   assign ovf_o = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      bin_d       = bin_q;
      scratch_d   = scratch_q;
      cnt_d       = cnt_q;
      dots_hold_d = dots_hold_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      bcd_d       = bcd_q;
      dots_d      = dots_q;
      nib         = '0;
      adj         = '0;
`ifdef BIN2BCD_OVF_EN
      ovf_hold_d  = ovf_hold_q;
      ovf_d       = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (start_i) begin
               bin_d       = bin_i;
               dots_hold_d = dp_i;
               scratch_d   = '0;
               cnt_d       = CW'(BIN_WIDTH);
               busy_d      = 1'b1;
               state_d     = SHIFT;
`ifdef BIN2BCD_OVF_EN
               ovf_hold_d  = 64'(bin_i) > MAX_V;
`endif
            end
         end
         SHIFT: begin
            // Adjust every nibble, then shift left by one; the adjusted top bit falls off.
            scratch_d[0] = bin_q[BIN_WIDTH-1];
            for (int i = 0; i < DIGITS - 1; i++) begin
               nib = scratch_q[4*i +: 4];
               adj = (nib >= 4'd5) ? nib + 4'd3 : nib;
               scratch_d[4*i+1 +: 4] = adj;
            end
            nib = scratch_q[SW-4 +: 4];
            adj = (nib >= 4'd5) ? nib + 4'd3 : nib;
            scratch_d[SW-3 +: 3] = adj[2:0];
            bin_d = {bin_q[BIN_WIDTH-2:0], 1'b0};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = DONE;
         end
         DONE: begin
            bcd_d   = scratch_q;
            dots_d  = dots_hold_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
`ifdef BIN2BCD_OVF_EN
            ovf_d   = ovf_hold_q;
            if (ovf_hold_q) bcd_d = {DIGITS{4'hE}};
`endif
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         bin_q       <= '0;
         scratch_q   <= '0;
         cnt_q       <= '0;
         dots_hold_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         bcd_q       <= '0;
         dots_q      <= '0;
`ifdef BIN2BCD_OVF_EN
         ovf_hold_q  <= 1'b0;
         ovf_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         bin_q       <= bin_d;
         scratch_q   <= scratch_d;
         cnt_q       <= cnt_d;
         dots_hold_q <= dots_hold_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         bcd_q       <= bcd_d;
         dots_q      <= dots_d;
`ifdef BIN2BCD_OVF_EN
         ovf_hold_q  <= ovf_hold_d;
         ovf_q       <= ovf_d;
`endif
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign bcd_o  = bcd_q;
   assign dots_o = dots_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomized bench for bin2bcd_seq against an arithmetic decimal-digit model.
module tb_bin2bcd_seq;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        start_i;
   logic [13:0] bin_i;
   logic [3:0]  dp_i;
   logic        busy_o, done_o, ovf_o;
   logic [15:0] bcd_o;
   logic [3:0]  dots_o;

   int n_chk = 0;
   int n_fail = 0;

   bin2bcd_seq #(.BIN_WIDTH(14), .DIGITS(4)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .bin_i(bin_i), .dp_i(dp_i),
      .busy_o(busy_o), .done_o(done_o), .ovf_o(ovf_o), .bcd_o(bcd_o), .dots_o(dots_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] exp_bcd(input int v);
      int m;
      logic [15:0] r;
`ifdef BIN2BCD_OVF_EN
      if (v > 9999) return 16'hEEEE;
`endif
      m = v % 10000;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(m % 10);
         m = m / 10;
      end
      return r;
   endfunction

   function automatic logic exp_ovf(input int v);
`ifdef BIN2BCD_OVF_EN
      return v > 9999;
`else
      return (v < 0);
`endif
   endfunction

   task automatic run_conv(input int v, input logic [3:0] dp, input string tag);
      int lat;
      logic [15:0] e;
      e = exp_bcd(v);
      @(negedge clk_i);
      start_i = 1'b1;
      bin_i   = 14'(v);
      dp_i    = dp;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      bin_i   = 14'($urandom);
      dp_i    = 4'($urandom);
      chk({tag, "_busy"}, 64'(busy_o), 64'(1));
      lat = 0;
      while (!done_o && lat < 40) begin
         @(posedge clk_i); #1;
         lat++;
      end
      chk({tag, "_lat"}, 64'(lat), 64'(15));
      chk({tag, "_bcd"}, 64'(bcd_o), 64'(e));
      chk({tag, "_dots"}, 64'(dots_o), 64'(dp));
      chk({tag, "_ovf"}, 64'(ovf_o), 64'(exp_ovf(v)));
      chk({tag, "_busy_end"}, 64'(busy_o), 64'(0));
      @(posedge clk_i); #1;
      chk({tag, "_done_pulse"}, 64'(done_o), 64'(0));
      repeat (3) begin
         @(posedge clk_i); #1;
         bin_i = 14'($urandom);
      end
      chk({tag, "_hold"}, 64'(bcd_o), 64'(e));
   endtask

   initial begin
      int v;
      int q[$];
      int last, ndone;
      rst_ni  = 1'b0;
      start_i = 1'b0;
      bin_i   = '0;
      dp_i    = '0;
      repeat (3) @(negedge clk_i);
      chk("rst_busy", 64'(busy_o), 64'(0));
      chk("rst_done", 64'(done_o), 64'(0));
      chk("rst_bcd", 64'(bcd_o), 64'(0));
      chk("rst_dots", 64'(dots_o), 64'(0));
      chk("rst_ovf", 64'(ovf_o), 64'(0));
      rst_ni = 1'b1;

      run_conv(1234, 4'b0100, "c1234");
      run_conv(0, 4'b0000, "c0");
      run_conv(9999, 4'b1111, "c9999");
      run_conv(5, 4'b0001, "c5");
      run_conv(12345, 4'b1010, "c12345");
      run_conv(16383, 4'b0011, "cmax");
      for (int i = 0; i < 12; i++) run_conv(int'($urandom_range(0, 16383)), 4'($urandom), "rnd");

      // Asynchronous reset in the middle of a conversion.
      @(negedge clk_i);
      start_i = 1'b1;
      bin_i   = 14'd4321;
      dp_i    = 4'b1000;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      repeat (5) @(posedge clk_i);
      #2 rst_ni = 1'b0;
      #1;
      chk("mid_rst_busy", 64'(busy_o), 64'(0));
      chk("mid_rst_done", 64'(done_o), 64'(0));
      chk("mid_rst_bcd", 64'(bcd_o), 64'(0));
      chk("mid_rst_dots", 64'(dots_o), 64'(0));
      chk("mid_rst_ovf", 64'(ovf_o), 64'(0));
      @(negedge clk_i);
      rst_ni = 1'b1;
      run_conv(1234, 4'b0100, "post_rst");

      // start held high, input toggling every cycle: accepts land every 16 edges.
      last  = -1;
      ndone = 0;
      for (int n = 0; n < 64; n++) begin
         @(negedge clk_i);
         start_i = 1'b1;
         v       = ($urandom & 1) ? 42 : 777;
         bin_i   = 14'(v);
         dp_i    = '0;
         @(posedge clk_i);
         if (n % 16 == 0) q.push_back(v);
         #1;
         if (done_o) begin
            ndone++;
            chk("b2b_gap", 64'(n - last), 64'(16));
            chk("b2b_q", 64'(q.size() > 0), 64'(1));
            if (q.size() > 0) chk("b2b_bcd", 64'(bcd_o), 64'(exp_bcd(q.pop_front())));
            last = n;
         end
      end
      start_i = 1'b0;
      chk("b2b_count", 64'(ndone), 64'(4));
      repeat (20) @(posedge clk_i);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential double-dabble converter that turns an unsigned binary value into packed BCD digits for the 7-segment display driver. It sits directly upstream of the display driver: `bcd_o` feeds its `data_i` and `dots_o` feeds its `dots_i`. Its outputs are held stable between conversions, so the display's multiplexing never sees partial results.

## Interface
- `BIN_WIDTH`, default 14: width of binary input; must be ≥ 4.
- `DIGITS`, default 4: number of BCD digits produced; matches the display's `DIGITS`.
- `clk_i`  in  1  system clock, rising edge.
- `rst_ni`  in  1  reset, asynchronous assert, active-low.
- `start_i`  in  1  conversion request; sampled only in IDLE.
- `bin_i`  in  BIN_WIDTH  unsigned value; captured on the accepting edge.
- `dp_i`  in  DIGITS  decimal-point mask; captured with `bin_i`.
- `busy_o`  out  1  conversion in progress; registered.
- `done_o`  out  1  single-cycle pulse when `bcd_o` updates.
- `ovf_o`  out  1  last converted value exceeded 10^DIGITS−1 (only with macro, see Configuration).
- `bcd_o`  out  DIGITS*4  packed BCD; digit 0 in [3:0]; held until next `done_o`.
- `dots_o`  out  DIGITS  captured `dp_i`; updated together with `bcd_o`.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - When `start_i`=1 at an edge: latch `bin_i` into the shift register and `dp_i` into a holding register.
  - Clear BCD scratch (DIGITS*4 bits) and set iteration counter = BIN_WIDTH.
  - Go to SHIFT.
- SHIFT, one iteration per cycle:
  - Every scratch nibble ≥ 5 gets +3.
  - Then shift {scratch, binreg} left by 1; the MSB of scratch is discarded.
  - Counter decrements by 1; when it reaches 0 after this cycle's update, go to DONE.
  - Counter width is $clog2(BIN_WIDTH+1).
- DONE:
  - Transfer scratch → `bcd_o` and holding → `dots_o`.
  - Set `ovf_o` from the range check.
  - Pulse `done_o`; go to IDLE.
- Range check: the captured value is compared against 10^DIGITS−1 at capture time; the flag is stored until DONE.
- `start_i` in SHIFT/DONE is ignored; it is not queued.
- `bin_i` and `dp_i` may change freely after capture.
- Reset at any time, including mid-conversion, forces:
  - State to IDLE.
  - `busy_o`, `done_o` and `ovf_o` to 0.
  - `bcd_o` to all zeros, `dots_o` to all zeros.
  - Scratch and counter cleared.
- After reset the display shows "0000" with no dots.

## Timing
- Edge E0: start accepted; `busy_o`=1 from E0.
- Edges E1..E_BIN_WIDTH: shift iterations.
- Edge E_(BIN_WIDTH+1), the DONE edge:
  - `bcd_o`, `dots_o` and `ovf_o` update.
  - `done_o`=1 for exactly that one cycle.
  - `busy_o`=0.
- Latency from accepting edge to valid output: BIN_WIDTH+1 cycles (15 at defaults).
- `start_i` high during the `done_o` cycle is accepted, since the state is IDLE. Back-to-back throughput is one conversion per BIN_WIDTH+2 cycles.
- All outputs are registered; there are no combinational input→output paths.

## Configuration
- Macro `BIN2BCD_OVF_EN`.
- Defined:
  - Captured value > 10^DIGITS−1 gives `ovf_o`=1 and `bcd_o` = every nibble 4'hE ("EEEE" on the display).
  - `dots_o` is still the captured mask.
  - In-range values give `ovf_o`=0.
- Undefined:
  - `ovf_o` is tied to 0 and the comparator is not built.
  - `bcd_o` = value mod 10^DIGITS, the natural truncation of the discarded scratch MSBs.

## Test plan
- Reset low mid-SHIFT, then high → `bcd_o`=16'h0000, `dots_o`=0, `busy_o`=0, `done_o`=0; next start converts normally.
- `bin_i`=1234, `dp_i`=4'b0100, `start_i` pulse → `done_o` exactly 15 cycles after the accepting edge; `bcd_o`=16'h1234, `dots_o`=4'b0100, `ovf_o`=0.
- Edge values:
  - `bin_i`=0 → 16'h0000.
  - `bin_i`=9999 → 16'h9999.
  - `bin_i`=5 → 16'h0005.
  - In each case `bcd_o` holds its value until the next `done_o`.
- `bin_i`=12345:
  - Macro defined → `bcd_o`=16'hEEEE, `ovf_o`=1.
  - Macro undefined → `bcd_o`=16'h2345, `ovf_o`=0.
- `start_i` held high continuously with `bin_i` changing between 42 and 777:
  - Exactly one `done_o` per 16 cycles.
  - Each result matches the value present at its accepting edge.
  - Mid-conversion changes to `bin_i` have no effect.
